// File: rtl/p_if.sv
// p_if: RV32I instruction-fetch stage. Assembles little-endian words one byte per cycle
// from the shared 8-bit memory port. Define P_IF_ICACHE_EN for a direct-mapped instruction cache.
module p_if #(
    parameter int ICACHE_LINES = 32
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        mem_busy,
    input  logic [7:0]  mem_din,
    output logic [31:0] mem_a,
    output logic        mem_re,
    input  logic        id_stall,
    input  logic        jump,
    input  logic [31:0] next_addr,
    output logic [31:0] inst_pc,
    output logic [31:0] inst,
    output logic        busy_out
);

    typedef enum logic [2:0] {F0, F1, F2, F3, F4, READY} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc;
    logic [31:0] pc_nxt;
    logic [31:0] inst_nxt;
    logic [31:0] inst_pc_nxt;
    logic [23:0] asm_q;
    logic [23:0] asm_nxt;
    logic        lost_q;
    logic        cache_hit;
    logic [31:0] cache_data;
    logic [31:0] word_full;

    assign word_full = {mem_din, asm_q};
    assign busy_out  = (state != READY);

    // A byte in flight is dropped whenever the port was taken away or the stage froze,
    // so every such cycle in F1-F4 sends the fetch back to byte 0.
    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        inst_nxt    = inst;
        inst_pc_nxt = inst_pc;
        asm_nxt     = asm_q;
        mem_a       = pc;
        mem_re      = 1'b0;
        case (state)
            F0: begin
                if (cache_hit) begin
                    inst_nxt    = cache_data;
                    inst_pc_nxt = pc;
                    state_nxt   = READY;
                end else if (!mem_busy) begin
                    mem_re    = 1'b1;
                    state_nxt = F1;
                end
            end
            F1: begin
                mem_a = pc + 32'd1;
                if (lost_q || mem_busy) begin
                    state_nxt = F0;
                end else begin
                    mem_re       = 1'b1;
                    asm_nxt[7:0] = mem_din;
                    state_nxt    = F2;
                end
            end
            F2: begin
                mem_a = pc + 32'd2;
                if (lost_q || mem_busy) begin
                    state_nxt = F0;
                end else begin
                    mem_re        = 1'b1;
                    asm_nxt[15:8] = mem_din;
                    state_nxt     = F3;
                end
            end
            F3: begin
                mem_a = pc + 32'd3;
                if (lost_q || mem_busy) begin
                    state_nxt = F0;
                end else begin
                    mem_re         = 1'b1;
                    asm_nxt[23:16] = mem_din;
                    state_nxt      = F4;
                end
            end
            F4: begin
                mem_a = pc + 32'd3;
                if (lost_q || mem_busy) begin
                    state_nxt = F0;
                end else begin
                    inst_nxt    = word_full;
                    inst_pc_nxt = pc;
                    state_nxt   = READY;
                end
            end
            READY: begin
                if (!id_stall) begin
                    pc_nxt    = jump ? next_addr : pc + 32'd4;
                    state_nxt = F0;
                end
            end
            default: state_nxt = F0;
        endcase
        if (rst_in || !rdy_in) begin
            mem_re = 1'b0;
        end
    end

    // lost_q remembers a freeze that interrupted a fetch; it is the only bit that moves while rdy_in is low.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state   <= F0;
            pc      <= 32'h0;
            inst    <= 32'h0;
            inst_pc <= 32'h0;
            asm_q   <= 24'h0;
            lost_q  <= 1'b0;
        end else if (rdy_in) begin
            state   <= state_nxt;
            pc      <= pc_nxt;
            inst    <= inst_nxt;
            inst_pc <= inst_pc_nxt;
            asm_q   <= asm_nxt;
            lost_q  <= 1'b0;
        end else if (state inside {F1, F2, F3, F4}) begin
            lost_q <= 1'b1;
        end
    end

`ifdef P_IF_ICACHE_EN
    localparam int IDX_W = $clog2(ICACHE_LINES);
    localparam int TAG_W = 30 - IDX_W;

    logic [ICACHE_LINES-1:0] line_valid;
    logic [TAG_W-1:0]        line_tag  [ICACHE_LINES];
    logic [31:0]             line_data [ICACHE_LINES];
    logic [IDX_W-1:0]        pc_idx;
    logic [TAG_W-1:0]        pc_tag;
    logic                    fill;

    assign pc_idx     = pc[IDX_W+1:2];
    assign pc_tag     = pc[31:IDX_W+2];
    assign cache_hit  = line_valid[pc_idx] && (line_tag[pc_idx] == pc_tag) && (pc[1:0] == 2'b00);
    assign cache_data = line_data[pc_idx];
    // Unaligned words are never cached since they could never hit.
    assign fill       = rdy_in && (state == F4) && !lost_q && !mem_busy && (pc[1:0] == 2'b00);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            line_valid <= '0;
        end else if (fill) begin
            line_valid[pc_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in && fill) begin
            line_tag[pc_idx]  <= pc_tag;
            line_data[pc_idx] <= word_full;
        end
    end
`else
    assign cache_hit  = 1'b0;
    assign cache_data = 32'h0;
`endif

endmodule
